// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions: opcodes, ALU/result encodings, control bundles and the
// immediate extractor used by the decode stage.
package riscv_pkg;

    localparam int unsigned Xlen = 64;

    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcJal    = 7'h6f;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcImm    = 7'h13;
    localparam logic [6:0] OpcReg    = 7'h33;
    localparam logic [6:0] OpcImm32  = 7'h1b;
    localparam logic [6:0] OpcReg32  = 7'h3b;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluLui  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        result_src_e result_src;
        alu_op_e     alu_ctrl;
        logic        word_op;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        auipc;
        imm_type_e   imm_type;
        logic        illegal;
    } ctrl_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            illegal;
        result_src_e     result_src;
        alu_op_e         alu_ctrl;
        logic            word_op;
        logic [2:0]      funct3;
        logic [Xlen-1:0] rd1;
        logic [Xlen-1:0] rd2;
        logic [Xlen-1:0] imm;
        logic [Xlen-1:0] pc;
        logic [Xlen-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } de_reg_t;

    function automatic logic [Xlen-1:0] imm_ext(input logic [31:0] instr, input imm_type_e t);
        logic [Xlen-1:0] imm;
        imm = '0;
        case (t)
            ImmI:    imm = {{52{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            ImmJ:    imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt is instr[30]; for immediate forms it only selects SRAI, never SUB.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt,
                                           input logic is_imm);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (alt && !is_imm) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry integer register file: two combinational read ports, one write port, x0 hardwired
// to zero and an optional same-cycle write-to-read bypass.
module register_file
    import riscv_pkg::*;
#(
    parameter int unsigned Width  = 64,
    parameter int unsigned Bypass = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       raddr1_i,
    input  logic [4:0]       raddr2_i,
    output logic [Width-1:0] rdata1_o,
    output logic [Width-1:0] rdata2_o,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [Width-1:0] wdata_i
);

    logic [Width-1:0] regs_q [32];
    logic             wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = '0;
        end else if ((Bypass != 0) && wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = '0;
        end else if ((Bypass != 0) && wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: control decode, immediates, register read, branch/jump resolution with
// redirect to fetch, wrong-path kill, and the D/E pipeline register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned W_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            PCSrcD,
    output logic            JalD,
    output logic [XLEN-1:0] PCTargetD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            IllegalE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic            WordOpE,
    output logic [2:0]      Funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1, rd2, imm, imm_e;
    logic            taken;
    logic            kill_q, kill_d;
    de_reg_t         de_q, de_d;

    assign opcode = InstrD[6:0];
    assign rd     = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];

    register_file #(
        .Width  (XLEN),
        .Bypass (W_BYPASS)
    ) u_register_file (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2),
        .we_i     (RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW)
    );

    always_comb begin
        ctrl = '0;
        case (opcode)
            OpcLui: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = AluLui;
                ctrl.imm_type  = ImmU;
            end
            OpcAuipc: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = AluLui;
                ctrl.imm_type  = ImmU;
                ctrl.auipc     = 1'b1;
            end
            OpcJal: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = ResPc4;
                ctrl.imm_type   = ImmJ;
                ctrl.jal        = 1'b1;
            end
            OpcJalr: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = ResPc4;
                ctrl.imm_type   = ImmI;
                ctrl.jalr       = 1'b1;
            end
            OpcBranch: begin
                if (funct3[2:1] == 2'b01) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.branch   = 1'b1;
                    ctrl.imm_type = ImmB;
                end
            end
            OpcLoad: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = ResMem;
                ctrl.imm_type   = ImmI;
            end
            OpcStore: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_type  = ImmS;
            end
            OpcImm, OpcImm32: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_type  = ImmI;
                ctrl.alu_ctrl  = alu_decode(funct3, InstrD[30], 1'b1);
                ctrl.word_op   = (opcode == OpcImm32);
            end
            OpcReg, OpcReg32: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_decode(funct3, InstrD[30], 1'b0);
                ctrl.word_op   = (opcode == OpcReg32);
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign imm = imm_ext(InstrD, ctrl.imm_type);
    // AUIPC folds PC+imm here so execute only needs to pass the B operand through.
    assign imm_e = ctrl.auipc ? (PCD + imm) : imm;

    always_comb begin
        case (funct3)
            3'b000:  taken = (rd1 == rd2);
            3'b001:  taken = (rd1 != rd2);
            3'b100:  taken = ($signed(rd1) < $signed(rd2));
            3'b101:  taken = ($signed(rd1) >= $signed(rd2));
            3'b110:  taken = (rd1 < rd2);
            3'b111:  taken = (rd1 >= rd2);
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcD = !kill_q && ctrl.branch && taken;
    assign JalD   = !kill_q && (ctrl.jal || ctrl.jalr);
    assign kill_d = PCSrcD || JalD;

    always_comb begin
        PCTargetD = '0;
        if (ctrl.jalr) begin
            PCTargetD = (rd1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else if (ctrl.jal || ctrl.branch) begin
            PCTargetD = PCD + imm;
        end
    end

    always_comb begin
        de_d = '0;
        if (!FlushE && !kill_q) begin
            de_d.reg_write  = ctrl.reg_write;
            de_d.mem_write  = ctrl.mem_write;
            de_d.alu_src    = ctrl.alu_src;
            de_d.illegal    = ctrl.illegal;
            de_d.result_src = ctrl.result_src;
            de_d.alu_ctrl   = ctrl.alu_ctrl;
            de_d.word_op    = ctrl.word_op;
            de_d.funct3     = ctrl.illegal ? 3'b000 : funct3;
            de_d.rd1        = rd1;
            de_d.rd2        = rd2;
            de_d.imm        = imm_e;
            de_d.pc         = PCD;
            de_d.pc_plus4   = PCPlus4D;
            de_d.rs1        = rs1;
            de_d.rs2        = rs2;
            de_d.rd         = rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q   <= '0;
            kill_q <= 1'b0;
        end else begin
            de_q   <= de_d;
            kill_q <= kill_d;
        end
    end

    assign RegWriteE   = de_q.reg_write;
    assign MemWriteE   = de_q.mem_write;
    assign ALUSrcE     = de_q.alu_src;
    assign IllegalE    = de_q.illegal;
    assign ResultSrcE  = de_q.result_src;
    assign ALUControlE = de_q.alu_ctrl;
    assign WordOpE     = de_q.word_op;
    assign Funct3E     = de_q.funct3;
    assign RD1E        = de_q.rd1;
    assign RD2E        = de_q.rd2;
    assign ImmExtE     = de_q.imm;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc_plus4;
    assign Rs1E        = de_q.rs1;
    assign Rs2E        = de_q.rs2;
    assign RdE         = de_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of instruction vectors plus hand sequences for reset, bypass,
// flush and kill; expected E-stage outputs go through a scoreboard queue.
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk, rst_n;
    logic [31:0] InstrD;
    logic [63:0] PCD, PCPlus4D, ResultW, PCTargetD;
    logic        RegWriteW, FlushE, PCSrcD, JalD;
    logic [4:0]  RdW;
    logic        RegWriteE, MemWriteE, ALUSrcE, IllegalE, WordOpE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [63:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    decode_stage #(.XLEN(64), .W_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .JalD(JalD), .PCTargetD(PCTargetD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .WordOpE(WordOpE),
        .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, as, ill;
        logic [1:0]  rsrc;
        logic [3:0]  alu;
        logic        wo;
        logic [2:0]  f3;
        logic [63:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } eout_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        ps, jl;
        logic [63:0] tgt;
        eout_t       e;
    } vec_t;

    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

    int     n_checks = 0;
    int     n_pass   = 0;
    logic   killed   = 1'b0;
    eout_t  sb_q[$];
    string  sb_name_q[$];
    vec_t   vecs[$];

    function automatic eout_t mk(input logic rw, mw, as, ill, input logic [1:0] rsrc,
                                 input logic [3:0] alu, input logic wo, input logic [2:0] f3,
                                 input logic [63:0] rd1, rd2, imm, pc,
                                 input logic [4:0] rs1, rs2, rd);
        eout_t e;
        e = '{rw: rw, mw: mw, as: as, ill: ill, rsrc: rsrc, alu: alu, wo: wo, f3: f3,
              rd1: rd1, rd2: rd2, imm: imm, pc: pc, pc4: pc + 64'd4, rs1: rs1, rs2: rs2,
              rd: rd};
        return e;
    endfunction

    function automatic eout_t nop_e(input logic [63:0] pc);
        return mk(1, 0, 1, 0, 2'b00, AluAdd, 0, 3'd0, 0, 0, 0, pc, 5'd0, 5'd0, 5'd0);
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic eout_t get_e();
        return {RegWriteE, MemWriteE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE, WordOpE,
                Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_e(input string name, input eout_t act, input eout_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One D slot: drive, check redirect now, check E outputs after the next rising edge.
    task automatic cycle(input string name, input logic [31:0] instr, input logic [63:0] pc,
                         input logic ps, input logic jl, input logic [63:0] tgt,
                         input eout_t exp, input logic flush = 1'b0, input logic we = 1'b0,
                         input logic [4:0] wrd = 5'd0, input logic [63:0] wdat = 64'd0);
        eout_t e;
        e = exp;
        if (killed) begin
            e  = '0;
            ps = 1'b0;
            jl = 1'b0;
        end
        if (flush) e = '0;
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 64'd4;
        FlushE    = flush;
        RegWriteW = we;
        RdW       = wrd;
        ResultW   = wdat;
        #1;
        check64({name, ".PCSrcD"}, {63'd0, PCSrcD}, {63'd0, ps});
        check64({name, ".JalD"}, {63'd0, JalD}, {63'd0, jl});
        check64({name, ".PCTargetD"}, PCTargetD, tgt);
        sb_q.push_back(e);
        sb_name_q.push_back(name);
        @(posedge clk);
        #1;
        killed = ps | jl;
        check_e({sb_name_q.pop_front(), ".E"}, get_e(), sb_q.pop_front());
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [63:0] pc,
                           input logic ps, input logic jl, input logic [63:0] tgt,
                           input eout_t e);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.ps = ps; v.jl = jl; v.tgt = tgt; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;

        // Register state used by the table: x1=x2=7, x3=0xDEAD, x5=0x203, x6=-1, x7=1.
        add_vec("beq_taken", enc_b(13'd16, 5'd2, 5'd1, 3'b000), 64'h100, 1, 0, 64'h110,
                mk(0, 0, 0, 0, 0, AluAdd, 0, 3'd0, 7, 7, 16, 64'h100, 1, 2, 16));
        add_vec("beq_not", enc_b(13'd16, 5'd5, 5'd1, 3'b000), 64'h120, 0, 0, 64'h130,
                mk(0, 0, 0, 0, 0, AluAdd, 0, 3'd0, 7, 64'h203, 16, 64'h120, 1, 5, 16));
        add_vec("branch_f3_010", enc_b(13'd16, 5'd2, 5'd1, 3'b010), 64'h140, 0, 0, 64'h0,
                mk(0, 0, 0, 1, 0, 4'd0, 0, 3'd0, 7, 7, 0, 64'h140, 1, 2, 16));
        add_vec("jalr", enc_i(12'd8, 5'd5, 3'b000, 5'd1, 7'h67), 64'h300, 0, 1, 64'h20A,
                mk(1, 0, 1, 0, 2'b10, AluAdd, 0, 3'd0, 64'h203, 0, 8, 64'h300, 5, 8, 1));
        add_vec("illegal_7f", 32'h0000_007F, 64'h400, 0, 0, 64'h0,
                mk(0, 0, 0, 1, 0, 4'd0, 0, 3'd0, 0, 0, 0, 64'h400, 0, 0, 0));
        add_vec("bltu_not", enc_b(13'd8, 5'd7, 5'd6, 3'b110), 64'h500, 0, 0, 64'h508,
                mk(0, 0, 0, 0, 0, AluAdd, 0, 3'b110, Ones, 1, 8, 64'h500, 6, 7, 8));
        add_vec("blt_taken", enc_b(-13'sd8, 5'd7, 5'd6, 3'b100), 64'h540, 1, 0, 64'h538,
                mk(0, 0, 0, 0, 0, AluAdd, 0, 3'b100, Ones, 1, 64'hFFFF_FFFF_FFFF_FFF8,
                   64'h540, 6, 7, 25));
        add_vec("addiw", enc_i(12'hFFF, 5'd1, 3'b000, 5'd9, 7'h1B), 64'h600, 0, 0, 64'h0,
                mk(1, 0, 1, 0, 0, AluAdd, 1, 3'd0, 7, 0, Ones, 64'h600, 1, 31, 9));
        add_vec("sub", enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd10, 7'h33), 64'h610, 0, 0, 64'h0,
                mk(1, 0, 0, 0, 0, AluSub, 0, 3'd0, 64'hDEAD, 7, 0, 64'h610, 3, 1, 10));
        add_vec("sltu", enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd13, 7'h33), 64'h618, 0, 0, 64'h0,
                mk(1, 0, 0, 0, 0, AluSltu, 0, 3'b011, 7, 7, 0, 64'h618, 1, 2, 13));
        add_vec("sd", enc_s(12'hFFC, 5'd2, 5'd5, 3'b011), 64'h620, 0, 0, 64'h0,
                mk(0, 1, 1, 0, 0, AluAdd, 0, 3'b011, 64'h203, 7, 64'hFFFF_FFFF_FFFF_FFFC,
                   64'h620, 5, 2, 28));
        add_vec("ld", enc_i(12'd16, 5'd2, 3'b011, 5'd11, 7'h03), 64'h630, 0, 0, 64'h0,
                mk(1, 0, 1, 0, 2'b01, AluAdd, 0, 3'b011, 7, 0, 16, 64'h630, 2, 16, 11));
        add_vec("jal", enc_j(21'h20, 5'd1), 64'h700, 0, 1, 64'h720,
                mk(1, 0, 0, 0, 2'b10, AluAdd, 0, 3'd0, 0, 0, 64'h20, 64'h700, 0, 0, 1));

        // Reset state.
        @(posedge clk);
        #1;
        check_e("reset.E", get_e(), '0);
        check64("reset.redirect", {62'd0, PCSrcD, JalD}, 64'd0);
        rst_n = 1'b1;

        cycle("first_slot_zero", 32'h0, 64'h0, 0, 0, 64'h0,
              mk(0, 0, 0, 1, 0, 4'd0, 0, 3'd0, 0, 0, 0, 64'h0, 0, 0, 0));
        cycle("addi_x1_5", enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), 64'h4, 0, 0, 64'h0,
              mk(1, 0, 1, 0, 0, AluAdd, 0, 3'd0, 0, 0, 5, 64'h4, 0, 5, 1));

        cycle("wb_x0", Nop, 64'h10, 0, 0, 0, nop_e(64'h10), 0, 1, 5'd0, 64'h55);
        cycle("wb_x1", Nop, 64'h14, 0, 0, 0, nop_e(64'h14), 0, 1, 5'd1, 64'd7);
        cycle("wb_x2", Nop, 64'h18, 0, 0, 0, nop_e(64'h18), 0, 1, 5'd2, 64'd7);
        cycle("wb_x5", Nop, 64'h1C, 0, 0, 0, nop_e(64'h1C), 0, 1, 5'd5, 64'h203);
        cycle("wb_x6", Nop, 64'h20, 0, 0, 0, nop_e(64'h20), 0, 1, 5'd6, Ones);
        cycle("wb_x7", Nop, 64'h24, 0, 0, 0, nop_e(64'h24), 0, 1, 5'd7, 64'd1);

        cycle("bypass_x3", enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33), 64'h40, 0, 0, 0,
              mk(1, 0, 0, 0, 0, AluAdd, 0, 3'd0, 64'hDEAD, 0, 0, 64'h40, 3, 0, 4),
              0, 1, 5'd3, 64'hDEAD);
        cycle("wb_x0_read", enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd4, 7'h33), 64'h44, 0, 0, 0,
              mk(1, 0, 0, 0, 0, AluAdd, 0, 3'd0, 0, 0, 0, 64'h44, 0, 0, 4),
              0, 1, 5'd0, 64'h77);

        // Each vector is followed by a NOP, which must become a bubble after a redirect.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].name, vecs[i].instr, vecs[i].pc, vecs[i].ps, vecs[i].jl,
                  vecs[i].tgt, vecs[i].e);
            cycle({vecs[i].name, ".next"}, Nop, vecs[i].pc + 64'd4, 0, 0, 64'h0,
                  nop_e(vecs[i].pc + 64'd4));
        end

        cycle("flush_add", enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33), 64'h800, 0, 0, 0,
              mk(1, 0, 0, 0, 0, AluAdd, 0, 3'd0, 64'hDEAD, 0, 0, 64'h800, 3, 0, 4), 1);
        cycle("jal_pre_flush", enc_j(21'h20, 5'd1), 64'h810, 0, 1, 64'h830,
              mk(1, 0, 0, 0, 2'b10, AluAdd, 0, 3'd0, 0, 0, 64'h20, 64'h810, 0, 0, 1));
        cycle("flush_and_kill", Nop, 64'h814, 0, 0, 0, nop_e(64'h814), 1);

        // Asynchronous reset while a redirect has set the kill flop.
        cycle("jal_pre_reset", enc_j(21'h20, 5'd1), 64'h900, 0, 1, 64'h920,
              mk(1, 0, 0, 0, 2'b10, AluAdd, 0, 3'd0, 0, 0, 64'h20, 64'h900, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check_e("async_reset.E", get_e(), '0);
        killed = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("jal_after_reset", enc_j(21'h20, 5'd1), 64'h900, 0, 1, 64'h920,
              mk(1, 0, 0, 0, 2'b10, AluAdd, 0, 3'd0, 0, 0, 64'h20, 64'h900, 0, 0, 1));
        cycle("jal_after_reset.next", Nop, 64'h904, 0, 0, 0, nop_e(64'h904));
        cycle("regfile_cleared", enc_r(7'h00, 5'd0, 5'd3, 3'b000, 5'd4, 7'h33), 64'h910,
              0, 0, 0, mk(1, 0, 0, 0, 0, AluAdd, 0, 3'd0, 0, 0, 0, 64'h910, 3, 0, 4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV64I decode stage: consumes the fetch stage's D-side registers (InstrD, PCD, PCPlus4D), reads operands from an internal 32x64 register file, generates immediates and control, and resolves branches and jumps in D, driving the redirect (PCSrcD, JalD, PCTargetD) back to fetch. It owns the D/E pipeline register feeding execute. It also accepts writeback-stage register writes.

## Interface
- XLEN, 64: datapath width; only 64 is supported.
- W_BYPASS, 1: 1 enables the same-cycle writeback-to-read bypass.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- InstrD / PCD / PCPlus4D  in  32/64/64  from fetch D register
- RegWriteW, RdW[4:0], ResultW[63:0]  in  writeback port
- FlushE  in  1  load a bubble into D/E this cycle
- PCSrcD, JalD  out  1  taken branch / JAL-or-JALR (combinational)
- PCTargetD  out  64  redirect target (combinational)
- RegWriteE, MemWriteE, ALUSrcE, IllegalE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
- ALUControlE  out  4  package encoding
- WordOpE  out  1  *W op: 32-bit result, sign-extended
- Funct3E  out  3  memory size/sign
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  64  registered data
- Rs1E, Rs2E, RdE  out  5  registered indices for execute forwarding

## Operation
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32. All others, including all-zero, are illegal: control is zeroed and IllegalE=1 is registered.
- Immediates are sign-extended to 64 bits: I, S, B (bit0=0), U (<<12), J (bit0=0).
- Register file:
  - x0 reads 0.
  - Write on posedge when RegWriteW && RdW!=0.
  - With W_BYPASS=1, a read of RdW in the same cycle returns ResultW.
- Branch compare in D on bypassed RD1/RD2: BEQ, BNE, BLT, BGE, BLTU, BGEU. Funct3 010/011 is illegal.
- PCTargetD:
  - JAL, branch: PCD+ImmExt.
  - JALR: (RD1+ImmExt) & ~1.
  - Otherwise: 0.
- PCSrcD=1 only for a taken branch. JalD=1 for JAL/JALR. Both are 0 when the current slot is killed or illegal.
- Kill flop (KillD):
  - Set on the posedge where PCSrcD|JalD=1; cleared otherwise.
  - While KillD=1 the instruction in D is the wrong-path fall-through: it is treated as a bubble and suppresses redirect.
  - A killed slot never asserts IllegalE.
- Bubble means all control outputs are 0, including IllegalE. Data fields are don't-care but are driven to 0.
- No interlock: RAW on branch/JALR operands from E/M is not resolved. The toolchain schedules these; execute forwards ALU operands via Rs1E/Rs2E.
- FlushE has priority over normal load.

## Timing
- Redirect outputs are combinational from InstrD, the register file, and KillD; they are valid the same cycle.
- D/E register: latency 1.
- Reset (rst_n=0), asynchronous:
  - All E outputs are 0.
  - KillD=0.
  - The register file is cleared to 0.
- The first cycle after reset sees InstrD=0: illegal but excluded from redirect. IllegalE=1 for that one slot is expected; execute masks it until the first valid instruction.
- Simultaneous cases:
  - FlushE with KillD: bubble.
  - Writeback to x0: ignored.
  - Writeback with a read of the same register: new value when W_BYPASS=1.
  - Back-to-back redirects are impossible, because the slot after a redirect is killed.
- PC arithmetic wraps modulo 2^64.

## Structure
- Package riscv_pkg holds:
  - Opcode constants.
  - ALUControl codes: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI-pass.
  - ResultSrc encoding and imm-type enum.
- Sub-module register_file holds the 32x64 storage, two read ports, one write port, and the bypass.
- Decoder, immediate generator, branch comparator and the D/E register live in decode_stage.

## Test plan
- Reset then ADDI x1,x0,5 → next cycle RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, RD1E=0. Assert rst_n mid-run → all E outputs 0 immediately.
- Writeback RdW=3, ResultW=0xDEAD while InstrD reads x3 → RD1E=0xDEAD (W_BYPASS=1). With RdW=0 → x0 stays 0.
- BEQ x1,x2,+16 at PC 0x100 with x1=x2 → PCSrcD=1, PCTargetD=0x110. The next cycle's InstrD becomes a bubble. With x1≠x2 → PCSrcD=0.
- JALR x1,8(x5) with x5=0x203 → JalD=1, PCTargetD=0x20A, ResultSrcE=10, PCPlus4E=PC+4.
- Opcode 0x7F → IllegalE=1 with all write enables 0. FlushE=1 during ADD → bubble.
- BLTU with x1=-1, x2=1 → not taken. BLT → taken. ADDIW → WordOpE=1.
